dmem_ctrl: RTL and testbench

Parametrised, multi-cycle data-memory controller that replaces the single-cycle word-only data memory in the CPU datapath. It accepts one load/store request at a time over a req/ready handshake and inserts a configurable number of wait states. It supports byte, halfword and word accesses, with sign or zero extension on loads. It is the memory stage for the upcoming multi-cycle CPU and supports lb/lbu/lh/lhu/lw/sb/sh/sw.

---
 rtl/dmem_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller.
//
// Accepts one load/store at a time, waits LATENCY cycles, performs the
// access, then pulses ready for one cycle. Supports byte, halfword and
// word accesses with sign/zero extension on loads. Lanes are
// little-endian.
//
// Handshake: req is sampled only while the controller is idle (busy=0).
// A rising edge with req=1 in IDLE captures we/size/uns/addr/wdata. The
// request inputs are ignored until the controller is idle again. ready is
// a single-cycle completion pulse. rdata and err are valid while ready=1.
// rdata then holds its value until the next completion.
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   : misaligned accesses do not write memory, return rdata=0,
//               and raise err alongside ready.
//   undefined : err is tied to 0, and misaligned addresses are
//               force-aligned.
//
// Parameters:
//   ADDR_W  - byte-address bits decoded (depth = 2^(ADDR_W-2) words)
//   LATENCY - wait states between acceptance and access (0..15)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   req         in   request strobe
//   we          in   1 = store, 0 = load
//   size        in   00 byte, 01 half, 10/11 word
//   uns         in   zero-extend loads when 1
//   addr        in   byte address
//   wdata       in   store data (low byte/half/word used)
//   ready       out  completion pulse
//   rdata       out  load result
//   busy        out  controller not idle
//   err         out  misalignment flag, qualified by ready
//   dbg_state_o out  current FSM state (debug observation)

module dmem_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q, rdata_d;

    logic                capture;
    logic                access;

    logic [31:0]         mem [DEPTH];

    // Address bits above ADDR_W are ignored, so addresses wrap.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY);
                    capture = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: lane selection, store merge, load extension
    // ------------------------------------------------------------------
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       word_r;
    logic [3:0]        be;
    logic [31:0]       wrep;
    logic [31:0]       merged;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_val;
    logic              misalign;

    assign word_idx = addr_q[ADDR_W-1:2];
    assign word_r   = mem[word_idx];

    always_comb begin
        be      = 4'b1111;
        wrep    = wdata_q;
        ld_byte = word_r[{addr_q[1:0], 3'b000} +: 8];
        // Halfword lanes are {addr[1],0} and {addr[1],1}; addr[0] is ignored.
        ld_half = word_r[{addr_q[1], 4'b0000} +: 16];
        ld_val  = word_r;
        case (size_q)
            2'b00: begin
                be     = 4'b0001 << addr_q[1:0];
                wrep   = {4{wdata_q[7:0]}};
                ld_val = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep   = {2{wdata_q[15:0]}};
                ld_val = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                be     = 4'b1111;
                wrep   = wdata_q;
                ld_val = word_r;
            end
        endcase
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = be[k] ? wrep[8*k +: 8] : word_r[8*k +: 8];
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    always_comb begin
        misalign = 1'b0;
        if (size_q == 2'b01) begin
            misalign = addr_q[0];
        end else if (size_q[1]) begin
            misalign = (addr_q[1:0] != 2'b00);
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Memory is not reset. The write only happens on the access edge, and
    // an asserted reset forces IDLE, which suppresses a pending store.
    always_ff @(posedge clock) begin
        if (access && we_q && !misalign) begin
            mem[word_idx] <= merged;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (access) begin
            if (misalign) begin
                rdata_d = 32'd0;
            end else if (!we_q) begin
                rdata_d = ld_val;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (capture) begin
                we_q    <= we;
                size_q  <= size;
                uns_q   <= uns;
                addr_q  <= addr[ADDR_W-1:0];
                wdata_q <= wdata;
            end
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= misalign;
        end
    end

    assign err = err_q && (state_q == S_RESP);
`else
    assign err = 1'b0;
`endif

    assign ready       = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign rdata       = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int LAT = 2;
  localparam int AW  = 12;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready;
  logic [31:0] rdata;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state_o;

  int total  = 0;
  int passes = 0;

  dmem_ctrl #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .size        (size),
    .uns         (uns),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .rdata       (rdata),
    .busy        (busy),
    .err         (err),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One request, issued at a negedge while the controller is idle. Checks
  // completion latency and pulse width, and returns rdata/err at ready.
  task automatic access(input string tag, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e);
    int n;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    n = 1;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    while (!ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT + 2));
    rd = rdata;
    e  = err;
    @(negedge clock);
    check({tag, " pulse"}, {31'd0, ready}, 32'd0);
    check({tag, " hold"}, rdata, rd);
  endtask

  logic [31:0] rd;
  logic        e;
  logic        seen_ready;

  initial begin
    // reset state
    @(negedge clock);
    @(negedge clock);
    check("rst ready", {31'd0, ready}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst state", {30'd0, dbg_state_o}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // sw / lw; store leaves rdata at its reset value
    access("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, rd, e);
    check("sw10 rdata", rd, 32'd0);
    check("sw10 err", {31'd0, e}, 32'd0);
    access("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, e);
    check("lw10 rdata", rd, 32'h12345678);
    check("lw10 err", {31'd0, e}, 32'd0);

    // byte store and sign/zero extended byte loads
    access("sb13", 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFFAB, rd, e);
    check("sb13 rdata kept", rd, 32'h12345678);
    access("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, e);
    check("lw10 after sb", rd, 32'hAB345678);
    access("lb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, rd, e);
    check("lb13", rd, 32'hFFFFFFAB);
    access("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, rd, e);
    check("lbu13", rd, 32'h000000AB);
    access("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, rd, e);
    check("lbu11", rd, 32'h00000056);

    // halfword store preserves lanes 0-1
    access("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, rd, e);
    access("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h12348001, rd, e);
    access("lh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'd0, rd, e);
    check("lh22", rd, 32'hFFFF8001);
    access("lhu22", 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, rd, e);
    check("lhu22", rd, 32'h00008001);
    access("lh20", 1'b0, 2'b01, 1'b0, 32'h20, 32'd0, rd, e);
    check("lh20", rd, 32'h00007788);
    access("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, e);
    check("lw20", rd, 32'h80017788);

    // address wrap modulo 2^ADDR_W
    access("sw1004", 1'b1, 2'b10, 1'b0, 32'h1004, 32'hCAFEF00D, rd, e);
    access("lw0004", 1'b0, 2'b10, 1'b0, 32'h0004, 32'd0, rd, e);
    check("lw0004 wrap", rd, 32'hCAFEF00D);

    // reset mid-operation drops the pending store
    access("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADBEEF, rd, e);
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h30; wdata = 32'hDEADDEAD;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    check("rstmid busy before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstmid busy", {31'd0, busy}, 32'd0);
    check("rstmid state", {30'd0, dbg_state_o}, 32'd0);
    check("rstmid rdata", rdata, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (ready) seen_ready = 1'b1;
    end
    check("rstmid no ready", {31'd0, seen_ready}, 32'd0);
    access("lw30", 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, rd, e);
    check("lw30 prior", rd, 32'h0BADBEEF);

    // misaligned word load
    access("sw40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, rd, e);
    access("lw42", 1'b0, 2'b10, 1'b0, 32'h42, 32'd0, rd, e);
`ifdef DMEM_MISALIGN_ERR_EN
    check("lw42 err", {31'd0, e}, 32'd1);
    check("lw42 rdata", rd, 32'd0);
    check("lw42 err cleared", {31'd0, err}, 32'd0);
`else
    check("lw42 err", {31'd0, e}, 32'd0);
    check("lw42 rdata", rd, 32'h11223344);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
